// File: rtl/ldtu_decoder_pkg.sv
// LDTU word decoder: shared codes, FSM encoding and word classification.
// Imported by the decoder top and its word FIFO.
package ldtu_decoder_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [1:0]  PFX_BASE5 = 2'b01;
  localparam logic [1:0]  PFX_BASEN = 2'b10;
  localparam logic [5:0]  PFX_SIG2  = 6'b001010;
  localparam logic [5:0]  PFX_SYNC  = 6'b001011;
  localparam logic [12:0] SYNC_PAT  = 13'b0101010101010;
  localparam logic [12:0] HDR_PAT   = 13'b1111000001111;
  localparam logic [31:0] IDLE_WORD = 32'hF000_0000;
  localparam logic [3:0]  FB_PFX    = 4'b1111;

  typedef enum logic {
    S_IDLE,
    S_UNPACK
  } state_t;

  typedef enum logic [2:0] {
    K_ERR,
    K_IDLE,
    K_BASE5,
    K_BASEN,
    K_SIG2,
    K_SYNC,
    K_HDR,
    K_FB
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [2:0] cnt;
  } dec_t;

  // Every word takes at least one unpack cycle, even when nothing is emitted.
  function automatic dec_t classify(input logic [31:0] w,
                                    input logic fb);
    dec_t d;
    d.kind = K_ERR;
    d.cnt  = 3'd1;
    if (fb) begin
      if (w[31:28] == FB_PFX) begin
        d.kind = K_FB;
        d.cnt  = 3'd2;
      end
    end else begin
      unique case (1'b1)
        w == IDLE_WORD: d.kind = K_IDLE;
        w[31:30] == PFX_BASE5: begin
          d.kind = K_BASE5;
          d.cnt  = 3'd5;
        end
        w[31:30] == PFX_BASEN: begin
          if (w[29:24] != 6'd0 && w[29:24] <= 6'd4) begin
            d.kind = K_BASEN;
            d.cnt  = w[26:24];
          end
        end
        w[31:26] == PFX_SIG2: begin
          d.kind = K_SIG2;
          d.cnt  = 3'd2;
        end
        w[31:26] == PFX_SYNC && w[25:13] == SYNC_PAT:
          d.kind = K_SYNC;
        w[31:26] == PFX_SYNC && w[25:13] == HDR_PAT:
          d.kind = K_HDR;
        default: ;
      endcase
    end
    return d;
  endfunction

  function automatic logic [12:0] sample_of(input logic [29:0] w,
                                            input kind_t k,
                                            input logic [2:0] idx);
    logic [5:0]  b;
    logic [12:0] s;
    case (idx)
      3'd0:    b = w[5:0];
      3'd1:    b = w[11:6];
      3'd2:    b = w[17:12];
      3'd3:    b = w[23:18];
      default: b = w[29:24];
    endcase
    case (k)
      K_BASE5, K_BASEN: s = {7'd0, b};
      K_SIG2, K_FB:     s = (idx == 3'd0) ? w[12:0] : w[25:13];
      K_SYNC, K_HDR:    s = w[12:0];
      default:          s = 13'd0;
    endcase
    return s;
  endfunction

  function automatic logic fb_par_ok(input logic [27:0] w);
    return (w[26] == ~^w[12:0]) && (w[27] == ~^w[25:13]);
  endfunction

endpackage

// File: rtl/ldtu_decoder_if.sv
// LDTU decoder word inputs and decoded sample outputs.
// master drives words, slave is the decoder.
interface ldtu_decoder_if;
  logic        fallback;
  logic [31:0] DATA_32;
  logic        Load;
  logic [31:0] DATA_32_FB;
  logic        Load_FB;
  logic [12:0] DATA_out;
  logic        Valid_out;
  logic        Orbit_out;
  logic        Frame_err;
  logic        Parity_err;
  logic        Overflow;

  modport master (
    output fallback, DATA_32, Load, DATA_32_FB, Load_FB,
    input  DATA_out, Valid_out, Orbit_out,
    input  Frame_err, Parity_err, Overflow
  );

  modport slave (
    input  fallback, DATA_32, Load, DATA_32_FB, Load_FB,
    output DATA_out, Valid_out, Orbit_out,
    output Frame_err, Parity_err, Overflow
  );
endinterface

// File: rtl/ldtu_dec_fifo.sv
// 4-deep 32-bit word FIFO with synchronous active-low reset and flush.
// A push into a full FIFO only lands when a pop happens the same cycle.
module ldtu_dec_fifo
  import ldtu_decoder_pkg::*;
(
  input  logic        CLK,
  input  logic        rst_b,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int CW = PTR_W + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = count == '0;
  assign full    = count == FULL_CNT;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!rst_b || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ldtu_decoder.sv
// LDTU decoder top: word capture, FIFO, and one-sample-per-cycle unpacker.
// All outputs are registered; DATA_out holds between valid samples.
module ldtu_decoder
  import ldtu_decoder_pkg::*;
(
  input logic           CLK,
  input logic           rst_b,
  ldtu_decoder_if.slave bus
);
  logic        fb_q;
  logic        flush;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [31:0] din;
  logic [31:0] head;
  dec_t        d_head;

  state_t      state;
  logic [29:0] word_q;
  kind_t       kind_q;
  logic [2:0]  cnt_q;
  logic [2:0]  idx_q;
  logic        last;
  logic        emit;
  logic [12:0] smp;

  logic [12:0] data_q;
  logic        valid_q;
  logic        orbit_q;
  logic        ferr_q;
  logic        perr_q;
  logic        ovf_q;

  // A mode change drops everything queued under the old mode.
  assign flush = bus.fallback != fb_q;
  assign din   = bus.fallback ? bus.DATA_32_FB : bus.DATA_32;
  assign push  = (bus.fallback ? bus.Load_FB : bus.Load) && !flush;

  assign last = idx_q == (cnt_q - 3'd1);
  assign pop  = !flush && !empty &&
                (state == S_IDLE || (state == S_UNPACK && last));

  assign d_head = classify(head, fb_q);
  assign emit   = kind_q != K_ERR && kind_q != K_IDLE;
  assign smp    = sample_of(word_q, kind_q, idx_q);

  ldtu_dec_fifo u_fifo (
    .CLK   (CLK),
    .rst_b (rst_b),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK) begin
    if (!rst_b) begin
      fb_q    <= bus.fallback;
      state   <= S_IDLE;
      word_q  <= '0;
      kind_q  <= K_ERR;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      orbit_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      fb_q    <= bus.fallback;
      valid_q <= 1'b0;
      orbit_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= push && full && !pop;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        if (state == S_UNPACK) begin
          valid_q <= emit;
          if (emit) data_q <= smp;
          orbit_q <= kind_q == K_HDR;
          ferr_q  <= kind_q == K_ERR;
          perr_q  <= kind_q == K_FB && idx_q == 3'd0 &&
                     !fb_par_ok(word_q[27:0]);
          idx_q   <= idx_q + 3'd1;
          if (last && empty) state <= S_IDLE;
        end
        if (pop) begin
          state  <= S_UNPACK;
          word_q <= head[29:0];
          kind_q <= d_head.kind;
          cnt_q  <= d_head.cnt;
          idx_q  <= '0;
        end
      end
    end
  end

  assign bus.DATA_out   = data_q;
  assign bus.Valid_out  = valid_q;
  assign bus.Orbit_out  = orbit_q;
  assign bus.Frame_err  = ferr_q;
  assign bus.Parity_err = perr_q;
  assign bus.Overflow   = ovf_q;

endmodule
